// File: rtl/system_fifo_frame_writer.sv
// system_fifo_frame_writer
//   Write-side sequencer for the per-step system FIFOs. After a `start`
//   pulse it accepts exactly N_WT solver results over a valid/ready stream,
//   holds them in a 2-entry skid buffer and drains them into the FIFO write
//   port, stalling on `fifo_full`. `frame_done` pulses once the last word
//   has been written.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rst_user              synchronous clear (same effect as reset)
//   start                 one-cycle pulse opening a frame
//   in_valid/in_data      solver result stream
//   in_ready              word accepted this cycle when in_valid is also high
//   fifo_full             downstream FIFO full (back-pressure)
//   fifo_wrreq/fifo_data  FIFO write port
//   busy                  frame in progress
//   frame_done            one-cycle pulse after the last write
//   err                   sticky: start seen while busy

`ifndef N_WindTurbine
`define N_WindTurbine 8
`endif

module system_fifo_frame_writer #(
  parameter int unsigned N_WT = `N_WindTurbine,
  parameter int unsigned DW   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rst_user,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          fifo_full,
  output logic          fifo_wrreq,
  output logic [DW-1:0] fifo_data,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);

  localparam int unsigned   CW     = $clog2(N_WT + 1);
  localparam logic [CW-1:0] C_N    = CW'(N_WT);
  localparam logic [CW-1:0] C_LAST = CW'(N_WT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_acc_cnt;
  logic [CW-1:0]   r_wr_cnt;
  logic [DW-1:0]   r_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_buf_cnt;
  logic [DW-1:0]   r_last;
  logic            r_frame_done;
  logic            r_err;

  logic            w_push;
  logic            w_pop;
  logic            w_last_acc;
  logic            w_last_wr;
  logic            w_open;
  logic            w_frame_end;

  assign in_ready   = (r_state == S_COLLECT) && (r_acc_cnt < C_N) && (r_buf_cnt != 2'd2);
  assign fifo_wrreq = (r_buf_cnt != 2'd0) && !fifo_full;

  assign w_push     = in_valid && in_ready;
  assign w_pop      = fifo_wrreq;
  assign w_last_acc = w_push && (r_acc_cnt == C_LAST);
  assign w_last_wr  = w_pop && (r_wr_cnt == C_LAST);
  assign w_open     = (r_state == S_IDLE) && start;

  // Head while writing; otherwise the most recently written word, so the
  // data bus never shows a stale buffer slot.
  assign fifo_data  = fifo_wrreq ? r_mem[r_rd_ptr] : r_last;

  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign err        = r_err;

  // COLLECT hands over to DRAIN on the accept of the last word (not one
  // cycle later) so the last write always happens in DRAIN, where the
  // frame end is detected on the write itself: busy falls and frame_done
  // rises one cycle after the last write.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_last_acc) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_last_wr) begin
          w_state_nxt = S_IDLE;
          w_frame_end = 1'b1;
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_acc_cnt    <= '0;
      r_wr_cnt     <= '0;
    end else if (rst_user) begin
      r_state      <= S_IDLE;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_acc_cnt    <= '0;
      r_wr_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_frame_end;
      if (start && (r_state != S_IDLE)) r_err <= 1'b1;

      if (w_open)      r_acc_cnt <= '0;
      else if (w_push) r_acc_cnt <= r_acc_cnt + CW'(1);

      if (w_open)      r_wr_cnt <= '0;
      else if (w_pop)  r_wr_cnt <= r_wr_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_buf_cnt <= '0;
      r_last    <= '0;
    end else if (rst_user) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_buf_cnt <= '0;
      r_last    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
        2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_system_fifo_frame_writer.sv
module tb_system_fifo_frame_writer;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rst_user;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          fifo_full;
  logic          fifo_wrreq;
  logic [DW-1:0] fifo_data;
  logic          busy;
  logic          frame_done;
  logic          err;

  logic          s_rst_user;
  logic          s_start;
  logic          s_in_valid;
  logic [DW-1:0] s_in_data;
  logic          s_in_ready;
  logic          s_fifo_full;
  logic          s_fifo_wrreq;
  logic [DW-1:0] s_fifo_data;
  logic          s_busy;
  logic          s_frame_done;
  logic          s_err;

  int n_vec  = 0;
  int n_fail = 0;
  int nw;
  int bp_wd [15];
  bit bp_rdy[15];

  always #5 clk = ~clk;

  system_fifo_frame_writer #(.N_WT(8), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rst_user(rst_user), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  system_fifo_frame_writer #(.N_WT(1), .DW(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .rst_user(s_rst_user), .start(s_start),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .fifo_full(s_fifo_full), .fifo_wrreq(s_fifo_wrreq), .fifo_data(s_fifo_data),
    .busy(s_busy), .frame_done(s_frame_done), .err(s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One stream cycle: drive, let combinational outputs settle, check, clock.
  // wd_e = expected write data this cycle, 0 = no write expected.
  task automatic cyc(input string tag, input bit full, input bit valid,
                     input bit rdy_e, input int wd_e);
    fifo_full = full;
    in_valid  = valid;
    in_data   = 64'(nw);
    #1;
    chk({tag, ".rdy"}, 64'(in_ready), 64'(rdy_e));
    chk({tag, ".wr"}, 64'(fifo_wrreq), 64'(wd_e != 0));
    if (wd_e != 0) chk({tag, ".data"}, fifo_data, 64'(wd_e));
    if (valid && rdy_e) nw++;
    step();
  endtask

  // Back-to-back frame of base..base+7; start at c0, writes c2..c9,
  // frame_done at c10. Returns positioned in c10 without clocking.
  task automatic run_plain(input string tag, input int base, input bit restart,
                           input bit err_e);
    nw    = base;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".busy1"}, 64'(busy), 64'(1));
    for (int c = 1; c <= 9; c++) begin
      if (restart && c == 4) start = 1'b1;
      cyc($sformatf("%s.c%0d", tag, c), 1'b0, c <= 8, c <= 8, (c >= 2) ? base + c - 2 : 0);
      start = 1'b0;
      if (restart && c == 4) chk({tag, ".err5"}, 64'(err), 64'(1));
    end
    in_valid = 1'b0;
    chk({tag, ".done"}, 64'(frame_done), 64'(1));
    chk({tag, ".busy10"}, 64'(busy), 64'(0));
    chk({tag, ".wr10"}, 64'(fifo_wrreq), 64'(0));
    chk({tag, ".hold10"}, fifo_data, 64'(base + 7));
    chk({tag, ".err10"}, 64'(err), 64'(err_e));
  endtask

  initial begin
    rst_n = 1'b0; rst_user = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_data = '0; fifo_full = 1'b0;
    s_rst_user = 1'b0; s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_fifo_full = 1'b0;
    bp_wd  = '{0, 0, 1, 0, 0, 0, 0, 0, 2, 3, 4, 5, 6, 7, 8};
    bp_rdy = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", 64'(in_ready), 64'(0));
    chk("rst.wr", 64'(fifo_wrreq), 64'(0));
    chk("rst.data", fifo_data, 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(frame_done), 64'(0));
    chk("rst.err", 64'(err), 64'(0));
    #2 rst_n = 1'b1;
    step();

    // Back-to-back frame, then a new start in the frame_done cycle (gaps)
    run_plain("b2b", 'h01, 1'b0, 1'b0);

    nw    = 'h21;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("gap.busy1", 64'(busy), 64'(1));
    for (int c = 1; c <= 16; c++)
      cyc($sformatf("gap.c%0d", c), 1'b0, (c % 2 == 1) || (c == 16), c <= 15,
          (c % 2 == 0) ? 'h21 + c / 2 - 1 : 0);
    in_valid = 1'b1;
    #1;
    chk("gap.rdy17", 64'(in_ready), 64'(0));
    chk("gap.done17", 64'(frame_done), 64'(1));
    chk("gap.wr17", 64'(fifo_wrreq), 64'(0));
    step();
    in_valid = 1'b0;
    chk("gap.done18", 64'(frame_done), 64'(0));

    // Back-pressure: fifo_full high in c3..c7, frame_done 5 cycles late
    nw    = 'h31;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 5) chk("bp.hold5", fifo_data, 64'h31);
      cyc($sformatf("bp.c%0d", c), (c >= 3) && (c <= 7), nw <= 'h38, bp_rdy[c],
          (bp_wd[c] != 0) ? 'h31 + bp_wd[c] - 1 : 0);
    end
    fifo_full = 1'b0;
    in_valid  = 1'b0;
    chk("bp.done15", 64'(frame_done), 64'(1));
    chk("bp.busy15", 64'(busy), 64'(0));
    step();

    // Protocol error: second start at c4, then a normal frame
    run_plain("perr", 'h41, 1'b1, 1'b1);
    run_plain("after", 'h51, 1'b0, 1'b1);
    step();

    // Mid-frame clear after 3 accepts
    nw    = 'h61;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 3; c++)
      cyc($sformatf("clr.c%0d", c), 1'b0, 1'b1, 1'b1, (c >= 2) ? 'h61 + c - 2 : 0);
    in_valid = 1'b1;
    rst_user = 1'b1;
    step();
    rst_user = 1'b0;
    in_valid = 1'b0;
    chk("clr.busy", 64'(busy), 64'(0));
    chk("clr.wr", 64'(fifo_wrreq), 64'(0));
    chk("clr.err", 64'(err), 64'(0));
    chk("clr.done", 64'(frame_done), 64'(0));
    chk("clr.rdy", 64'(in_ready), 64'(0));
    chk("clr.data", fifo_data, 64'(0));
    step();
    chk("clr.done2", 64'(frame_done), 64'(0));
    chk("clr.wr2", 64'(fifo_wrreq), 64'(0));
    // start together with rst_user is ignored
    start    = 1'b1;
    rst_user = 1'b1;
    step();
    start    = 1'b0;
    rst_user = 1'b0;
    chk("clrst.busy", 64'(busy), 64'(0));
    chk("clrst.rdy", 64'(in_ready), 64'(0));
    run_plain("fresh", 'h71, 1'b0, 1'b0);
    step();

    // Asynchronous reset mid-frame, between clock edges
    nw    = 'h81;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc("ar.c1", 1'b0, 1'b1, 1'b1, 0);
    cyc("ar.c2", 1'b0, 1'b1, 1'b1, 'h81);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.rdy", 64'(in_ready), 64'(0));
    chk("ar.wr", 64'(fifo_wrreq), 64'(0));
    chk("ar.data", fifo_data, 64'(0));
    chk("ar.busy", 64'(busy), 64'(0));
    chk("ar.done", 64'(frame_done), 64'(0));
    chk("ar.err", 64'(err), 64'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    chk("ar.busy2", 64'(busy), 64'(0));

    // N_WT=1 latency: start t, accept t+1, write t+2, frame_done t+3
    s_start = 1'b1;
    step();
    s_start    = 1'b0;
    s_in_valid = 1'b1;
    s_in_data  = 64'hAB;
    #1;
    chk("n1.rdy1", 64'(s_in_ready), 64'(1));
    chk("n1.busy1", 64'(s_busy), 64'(1));
    step();
    s_in_valid = 1'b0;
    chk("n1.wr2", 64'(s_fifo_wrreq), 64'(1));
    chk("n1.data2", s_fifo_data, 64'hAB);
    chk("n1.done2", 64'(s_frame_done), 64'(0));
    step();
    chk("n1.done3", 64'(s_frame_done), 64'(1));
    chk("n1.busy3", 64'(s_busy), 64'(0));
    chk("n1.wr3", 64'(s_fifo_wrreq), 64'(0));
    step();
    chk("n1.done4", 64'(s_frame_done), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
